proc_core_n: RTL

Parametrised multicycle processor core, the next generation of the team's 16-bit bus-based CPU. Data width, address width and reset vector are configurable. The core has a full Z/N/C flag set with seven branch conditions, a bitwise AND, and variable-latency req/ack handshakes on separate instruction and data ports. It replaces the fixed-wait FSM and sits between the ROM and RAM wrappers at the top level.

---
 rtl/proc_core_n_if.sv | 31 +++
 rtl/proc_core_n.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/proc_core_n_if.sv
// Instruction and data memory handshake bundle for proc_core_n.
// The core is the master on both ports; memories (or a bench) are the slave.
interface proc_core_n_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          imem_ack;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/proc_core_n.sv
// proc_core_n: parametrised multicycle core with Z/N/C flags, seven branch
// conditions and variable-latency req/ack instruction and data ports.
module proc_core_n #(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Run,
  output logic          Done,
  proc_core_n_if.master bus
);
  localparam int SW = $clog2(DW);
  localparam logic [AW-1:0] PC_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, MEM} state_e;
  typedef enum logic [2:0] {
    OP_MV = 3'd0, OP_MVT = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
    OP_LD = 3'd4, OP_ST  = 3'd5, OP_AND = 3'd6, OP_SHF = 3'd7
  } op_e;

  state_e        state;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [DW-1:0] r [0:6];
  logic          z, n, c;
  logic          dmem_we_q;
  logic [AW-1:0] dmem_addr_q;
  logic [DW-1:0] dmem_wdata_q;

  op_e           op;
  logic          imm, is_mem;
  logic [2:0]    rx, ry;
  logic [DW-1:0] d9, pc_ext, x_val, y_val, b_val;
  logic [SW-1:0] amt;
  logic [DW-1:0] res, wb_data;
  logic [DW:0]   sum;
  logic          c_new, flag_en, wr_en, cond_ok, taken, wb_en;

  assign op     = op_e'(ir[15:13]);
  assign imm    = ir[12];
  assign rx     = ir[11:9];
  assign ry     = ir[2:0];
  assign d9     = {{(DW-9){ir[8]}}, ir[8:0]};
  assign is_mem = (op == OP_LD) || (op == OP_ST);
  assign amt    = b_val[SW-1:0];

  assign bus.imem_req   = (state == FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = (state == MEM);
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign Done = ((state == EXEC) && !is_mem) || ((state == MEM) && bus.dmem_ack);

  // Operand fetch: r7 reads as the zero-extended pc.
  always_comb begin
    pc_ext = '0;
    pc_ext[AW-1:0] = pc;
    x_val = (rx == 3'd7) ? pc_ext : r[rx];
    y_val = (ry == 3'd7) ? pc_ext : r[ry];
    b_val = imm ? d9 : y_val;
  end

  // Branch condition select from the flag set.
  always_comb begin
    unique case (rx)
      3'd0: cond_ok = 1'b1;
      3'd1: cond_ok = z;
      3'd2: cond_ok = !z;
      3'd3: cond_ok = !c;
      3'd4: cond_ok = c;
      3'd5: cond_ok = !n;
      3'd6: cond_ok = n;
      default: cond_ok = 1'b0;
    endcase
  end

  // ALU, shifter and result/flag enables for the EXEC cycle.
  always_comb begin
    res = '0; sum = '0; c_new = 1'b0;
    flag_en = 1'b0; wr_en = 1'b0; taken = 1'b0;
    unique case (op)
      OP_MV: begin res = b_val; wr_en = 1'b1; end
      OP_MVT: begin
        if (imm) begin
          res[DW-1 -: 8] = ir[7:0];
          wr_en = 1'b1;
        end else begin
          taken = cond_ok;
        end
      end
      OP_ADD: begin
        sum = {1'b0, x_val} + {1'b0, b_val};
        res = sum[DW-1:0]; c_new = sum[DW];
        wr_en = 1'b1; flag_en = 1'b1;
      end
      OP_SUB: begin
        res = x_val - b_val; c_new = (x_val >= b_val);
        wr_en = 1'b1; flag_en = 1'b1;
      end
      OP_AND: begin res = x_val & b_val; wr_en = 1'b1; flag_en = 1'b1; end
      OP_SHF: begin
        unique case (ir[6:5])
          2'b00: res = x_val << amt;
          2'b01: res = x_val >> amt;
          2'b10: res = $signed(x_val) >>> amt;
          default: res = DW'({x_val, x_val} >> amt);
        endcase
        wr_en = 1'b1; flag_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Single writeback path: ALU result in EXEC, load data on the MEM ack.
  always_comb begin
    wb_en = 1'b0;
    wb_data = res;
    if (state == EXEC && !is_mem) begin
      wb_en = wr_en;
    end else if (state == MEM && bus.dmem_ack && !dmem_we_q) begin
      wb_en = 1'b1;
      wb_data = bus.dmem_rdata;
    end
  end

  // Control FSM, instruction register and latched data-port request.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= IDLE;
      ir           <= '0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (Run) state <= FETCH;
        FETCH: begin
          if (bus.imem_ack) begin
            ir    <= bus.imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_mem) begin
            dmem_addr_q  <= y_val[AW-1:0];
            dmem_wdata_q <= x_val;
            dmem_we_q    <= (op == OP_ST);
            state        <= MEM;
          end else begin
            state <= Run ? FETCH : IDLE;
          end
        end
        MEM: if (bus.dmem_ack) state <= Run ? FETCH : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Architectural state: pc (fetch increment, r7 write overrides it later), flags, r0-r6.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc <= RESET_PC;
      z  <= 1'b0;
      n  <= 1'b0;
      c  <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) r[i] <= '0;
    end else begin
      if (state == FETCH && bus.imem_ack)
        pc <= pc + PC_ONE;
      else if (wb_en && rx == 3'd7)
        pc <= wb_data[AW-1:0];
      else if (state == EXEC && taken)
        pc <= pc + d9[AW-1:0];
      if (state == EXEC && flag_en) begin
        z <= (res == '0);
        n <= res[DW-1];
        c <= c_new;
      end
      if (wb_en && rx != 3'd7) r[rx] <= wb_data;
    end
  end
endmodule
